// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: FSM states and status byte layout.
package uart_tx_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_FULL = 1;
    localparam int unsigned STAT_OVF  = 2;

endpackage

// File: rtl/uart_tx_port_if.sv
// Parallel-port side of the UART transmitter: write strobe/data in, line and status out.
interface uart_tx_port_if;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;
    logic [7:0] status;

    modport master (
        output wr_req, wr_data,
        input  tx, busy, full, overflow, status
    );

    modport slave (
        input  wr_req, wr_data,
        output tx, busy, full, overflow, status
    );
endinterface

// File: rtl/uart_tx_port_fifo.sv
// Circular-buffer byte FIFO with a count register; push when full / pop when empty are ignored.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count register defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter fed by the parallel output port through a small FIFO.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_port_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        wr_req_q;
    logic        overflow_q, overflow_d;

    logic        wr_pulse, push, pop, baud_last;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [7:0]  status;

    assign wr_pulse  = bus.wr_req & ~wr_req_q;
    // Full is sampled before any same-cycle pop, so a write while full is always dropped.
    assign push      = wr_pulse & ~fifo_full;
    assign baud_last = (baud_cnt_q == BAUD_LAST);

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (wr_pulse & fifo_full);
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_dout;
                    tx_d       = 1'b0;
                    baud_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = DATA;
                end
            end
            DATA: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_req_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_req_q   <= bus.wr_req;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = (state_q != IDLE) | ~fifo_empty;
        status[STAT_FULL] = fifo_full;
        status[STAT_OVF]  = overflow_q;
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = status[STAT_BUSY];
    assign bus.full     = status[STAT_FULL];
    assign bus.overflow = status[STAT_OVF];
    assign bus.status   = status;
endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench: a timeline model of accepted writes and frame start times predicts tx/busy/status every cycle.
module tb_uart_tx_port;
    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_port_if bus ();

    uart_tx_port #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: every accepted byte with its acceptance edge and the edge its frame starts.
    int         acc_t[$];
    int         st_t[$];
    logic [7:0] byte_q[$];
    logic       ovf_m   = 1'b0;
    logic       prev_req = 1'b0;

    function automatic int last_end();
        if (st_t.size() == 0) return 0;
        return st_t[st_t.size()-1] + FRAME;
    endfunction

    function automatic logic exp_tx(int c);
        for (int i = 0; i < st_t.size(); i++) begin
            if (c >= st_t[i] && c < st_t[i] + FRAME) begin
                int slot = (c - st_t[i]) / CPB;
                logic [7:0] b = byte_q[i];
                if (slot == 0) return 1'b0;
                if (slot == 9) return 1'b1;
                return b[slot-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int c);
        for (int i = 0; i < acc_t.size(); i++)
            if (acc_t[i] <= c && st_t[i] + FRAME > c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_full(int c);
        int n = 0;
        for (int i = 0; i < acc_t.size(); i++)
            if (acc_t[i] <= c && st_t[i] > c) n++;
        return (n == DEPTH);
    endfunction

    task automatic model_edge();
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.wr_req && !prev_req) begin
                int occ = 0;
                for (int i = 0; i < acc_t.size(); i++)
                    if (acc_t[i] < cyc && st_t[i] >= cyc) occ++;
                if (occ == DEPTH) begin
                    ovf_m = 1'b1;
                end else begin
                    int s = (cyc + 1 > last_end()) ? cyc + 1 : last_end();
                    acc_t.push_back(cyc);
                    st_t.push_back(s);
                    byte_q.push_back(bus.wr_data);
                end
            end
            prev_req = bus.wr_req;
        end
    endtask

    task automatic check_all(string tag);
        logic       etx  = exp_tx(cyc);
        logic       eb   = exp_busy(cyc);
        logic [7:0] est  = {5'b0, ovf_m, exp_full(cyc), eb};
        checks++;
        assert (bus.tx === etx) else begin
            failures++;
            $error("FAIL %s_tx cyc=%0d got=%b exp=%b", tag, cyc, bus.tx, etx);
        end
        checks++;
        assert (bus.busy === eb) else begin
            failures++;
            $error("FAIL %s_busy cyc=%0d got=%b exp=%b", tag, cyc, bus.busy, eb);
        end
        checks++;
        assert (bus.status === est) else begin
            failures++;
            $error("FAIL %s_status cyc=%0d got=%h exp=%h", tag, cyc, bus.status, est);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        int n = last_end() - cyc;
        idle((n > 0 ? n : 0) + 5);
    endtask

    task automatic write_byte(logic [7:0] b);
        bus.wr_data = b;
        bus.wr_req  = 1'b1;
        tick();
        bus.wr_req  = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        acc_t.delete();
        st_t.delete();
        byte_q.delete();
        ovf_m    = 1'b0;
        prev_req = 1'b0;
        #1;
        check_all("rst");
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.wr_data = '0;
        do_reset();

        idle(50);
        checks++;
        assert (bus.status === 8'h00) else begin
            failures++;
            $error("FAIL idle_status got=%h exp=00", bus.status);
        end

        write_byte(8'hA5);
        drain();

        bus.wr_data = 8'h3C;
        bus.wr_req  = 1'b1;
        idle(300);
        bus.wr_req  = 1'b0;
        drain();

        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        checks++;
        assert (bus.full === 1'b1 && bus.overflow === 1'b0) else begin
            failures++;
            $error("FAIL five_full got=%b/%b exp=1/0", bus.full, bus.overflow);
        end
        drain();

        for (int i = 0; i < 6; i++) write_byte(8'(8'h10 + i));
        checks++;
        assert (bus.overflow === 1'b1) else begin
            failures++;
            $error("FAIL six_ovf got=%b exp=1", bus.overflow);
        end
        drain();
        checks++;
        assert (bus.overflow === 1'b1) else begin
            failures++;
            $error("FAIL ovf_sticky got=%b exp=1", bus.overflow);
        end

        write_byte(8'hFF);
        begin
            int target = st_t[st_t.size()-1] + 35;
            while (cyc < target) tick();
        end
        do_reset();
        checks++;
        assert (bus.tx === 1'b1 && bus.busy === 1'b0 && bus.overflow === 1'b0) else begin
            failures++;
            $error("FAIL midframe_rst got=%b%b%b exp=100", bus.tx, bus.busy, bus.overflow);
        end
        write_byte(8'h81);
        drain();

        repeat (30) begin
            if ($urandom_range(0, 9) == 0) begin
                write_byte(8'($urandom));
                idle($urandom_range(0, 60));
                do_reset();
            end else begin
                write_byte(8'($urandom));
                idle($urandom_range(0, 60));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped serial output peripheral that consumes the byte the processor's parallel output port writes, and transmits it on UART_TXD.
- Sits directly downstream of the parallel output stage. It is instantiated in the top-level next to the data memory and the parallel input/output blocks.
- Buffers CPU writes in a small FIFO and serializes each byte as 8N1, LSB first.
- Returns a status byte to the parallel input stage, so software can poll before writing.

Parameters:
- CLK_FREQ, 50000000, frequency of clk in Hz.
- BAUD, 115200, line rate in bit/s. Localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); must be >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock (CLOCK_50).
- rst  input  1  asynchronous, active-high reset.
- wr_req  input  1  write strobe from the parallel output stage. Level signal, synchronous to clk; one write per rising edge.
- wr_data  input  8  byte to send; sampled on the cycle the wr_req rising edge is detected.
- tx  output  1  serial line to UART_TXD; idle high.
- busy  output  1  high while the FIFO is non-empty or the FSM is not in IDLE.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; set when a write is dropped; cleared only by rst.
- status  output  8  {5'b0, overflow, full, busy}, read back through the parallel input stage.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO emptied, FSM=IDLE, all counters 0, wr_req_d=0.
- Write detect:
  - wr_req_d is a register of wr_req.
  - A write is accepted at the clk edge where wr_req=1 and wr_req_d=0.
  - A held-high strobe (slow CPU clock) therefore yields exactly one write.
- Write acceptance:
  - If the FIFO is not full, wr_data is pushed and count increments.
  - If the FIFO is full, the byte is dropped and overflow is set.
  - Full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs in that cycle.
- FIFO: circular buffer with rd_ptr/wr_ptr wrapping modulo FIFO_DEPTH and a count register.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- FSM states IDLE, START, DATA, STOP; one baud counter (0..CLKS_PER_BIT-1) and one bit counter (0..7).
  - IDLE: tx=1. If the FIFO is non-empty, at the next edge: pop head into the shift register, tx=0, baud_cnt=0, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx=shift[0], bit_cnt=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles; shift right, LSB first. After bit 7, tx=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START (no idle gap); otherwise go to IDLE.
- tx is driven from a register (glitch-free).
- Latency: write accepted at edge N; tx falls at edge N+1 if the FSM was IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- busy falls on the same edge the FSM returns to IDLE with an empty FIFO.
- Writes during an active frame are queued; they never disturb the frame in progress.

Decomposition:
- Shared package: the FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the status bit positions (BUSY=0, FULL=1, OVF=2).
- One natural sub-module, uart_tx_fifo (parameter FIFO_DEPTH, 8-bit data): push, pop, dout, full, empty.
- Edge detect, FSM, baud/bit counters and the status flags stay in uart_tx_port.

Test Plan (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10):
- Reset, then idle 50 cycles -> tx=1, busy=0, status=8'h00.
- Single write 8'hA5 -> tx, in 10-cycle slots starting one edge after acceptance, is 0,1,0,1,0,0,1,0,1,1. busy stays high for 100 cycles, then falls.
- wr_req held high for 300 cycles with wr_data=8'h3C -> exactly one frame sent; no second frame.
- Five writes 8'h01..8'h05 in 10 cycles (first already popped) -> five contiguous frames (500 cycles, no idle gap), full high after the 5th write, overflow=0.
- Six writes 8'h10..8'h15 in 10 cycles -> the 6th is dropped, overflow=1 and stays 1. Only five frames are sent.
- Assert rst at cycle 35 of a frame carrying 8'hFF -> tx=1 immediately, busy=0, overflow=0, FIFO empty. A new write of 8'h81 then sends a clean full frame.
